// File: rtl/mwadd_pkg.sv
// Shared types and constants for the sequential multi-word adder.
// Holds the FSM encoding, the fixed word width and the index-width helper.
package mwadd_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-word operand still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prefix_adder_32bit.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry in and carry out.
// Purely combinational; used once per word by multiword_add_seq.
module prefix_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] gg;
  logic [31:0] pp;
  logic [32:0] c;

  always_comb begin
    gg = a & b;
    pp = a ^ b;
    // Each level doubles the span; bits below the span keep their propagate.
    for (int l = 0; l < 5; l++) begin
      gg = gg | (pp & (gg << (1 << l)));
      pp = pp & ((pp << (1 << l)) | ((32'd1 << (1 << l)) - 32'd1));
    end
    c    = {gg | (pp & {32{cin}}), cin};
    sum  = (a ^ b) ^ c[31:0];
    cout = c[32];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential W-bit adder (W = 32*NUM_WORDS) iterating prefix_adder_32bit once per word.
// Optional MWADD_OVF_EN adds out_ovf, the signed overflow of the full-width add.
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] in_a,
  input  logic [WORD_W*NUM_WORDS-1:0] in_b,
  input  logic                        in_cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_sum,
  output logic                        out_cout,
`ifdef MWADD_OVF_EN
  output logic                        busy,
  output logic                        out_ovf
`else
  output logic                        busy
`endif
);

  localparam int IW = idx_w(NUM_WORDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, and the result
  // is held unchanged in DONE until out_ready is seen.
  state_t                           state;
  logic [IW-1:0]                    idx;
  logic                             carry;
  logic [NUM_WORDS-1:0][WORD_W-1:0] a_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0] b_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0] sum_q;

  logic [WORD_W-1:0] a_w;
  logic [WORD_W-1:0] b_w;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  assign a_w = a_q[idx];
  assign b_w = b_q[idx];

  prefix_adder_32bit u_add (
    .a    (a_w),
    .b    (b_w),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      out_cout <= 1'b0;
`ifdef MWADD_OVF_EN
      out_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            carry <= in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= add_sum;
          carry      <= add_cout;
          idx        <= idx + 1'b1;
          if (idx == LAST) begin
            out_cout <= add_cout;
`ifdef MWADD_OVF_EN
            // Carry into the MSB is recovered from the top bit's sum equation.
            out_ovf  <= (a_w[WORD_W-1] ^ b_w[WORD_W-1] ^ add_sum[WORD_W-1]) ^ add_cout;
`endif
            idx      <= '0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed cases plus random traffic
// checked by a scoreboard against an arithmetic reference model.
module tb_multiword_add_seq;

  localparam int NW = 4;
  localparam int W  = 32 * NW;
  localparam int EW = W + 2;
`ifdef MWADD_OVF_EN
  localparam logic [EW-1:0] EXP_MASK = {EW{1'b1}};
`else
  localparam logic [EW-1:0] EXP_MASK = {1'b0, {(EW-1){1'b1}}};
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef MWADD_OVF_EN
  logic         out_ovf;
`endif

  multiword_add_seq #(.NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef MWADD_OVF_EN
    .busy      (busy),
    .out_ovf   (out_ovf)
`else
    .busy      (busy)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            errors = 0;
  int            checks = 0;
  int            ready_mode = 0;  // 0: always ready, 1: stalled, 2: random
  logic [EW-1:0] exp_q[$];

  // Reference: {ovf, cout, sum} of a + b + cin as plain wide arithmetic.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
    logic [W:0] s;
    logic       ovf;
    s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s};
  endfunction

  function automatic logic [EW-1:0] got();
`ifdef MWADD_OVF_EN
    return {out_ovf, out_cout, out_sum};
`else
    return {1'b0, out_cout, out_sum};
`endif
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 4))
      0:       r = '1;
      1:       r = '0;
      2:       r[32*$urandom_range(0, NW-1) +: 32] = 32'hFFFF_FFFF;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- out_ready driver ----------------
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  always begin
    logic [EW-1:0] e;
    @(negedge clk);
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", got());
      end else begin
        e = exp_q.pop_front();
        chk("result", got(), e & EXP_MASK);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the falling edge of the first cycle after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input bit expect_result);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
      return;
    end
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    if (expect_result) exp_q.push_back(model(a, b, cin));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", EW'(exp_q.size()), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [EW-1:0] e;
    int            n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", EW'(in_ready), EW'(1));
    chk("reset_out_valid", EW'(out_valid), '0);
    chk("reset_busy", EW'(busy), '0);
    chk("reset_result", got(), '0);
    rst = 1'b0;

    // all-ones + 0 + 1: carry ripples through every word, latency check
    send('1, '0, 1'b1, 1'b1);
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_latency", EW'(n), EW'(NW + 1));
    chk("t1_sum", EW'(out_sum), '0);
    chk("t1_cout", EW'(out_cout), EW'(1));
    chk("t1_busy_done", EW'(busy), EW'(1));
    chk("t1_in_ready_done", EW'(in_ready), '0);
    @(negedge clk);
    chk("t1_done_one_cycle", EW'(out_valid), '0);
    chk("t1_back_idle", EW'(in_ready), EW'(1));

    // inter-word carry
    send({96'd0, 32'hFFFF_FFFF}, W'(1), 1'b0, 1'b1);
    drain();

    // held result under backpressure while in_valid and in_a toggle
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    send(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'b1);
    e = exp_q[0];
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", EW'(out_valid), EW'(1));
      chk("hold_sum", EW'(out_sum), EW'(e[W-1:0]));
      chk("hold_in_ready", EW'(in_ready), '0);
      in_valid = 1'b1;
      in_a     = rand_w();
      @(negedge clk);
    end
    in_valid   = 1'b0;
    ready_mode = 0;
    n = 0;
    while (out_valid === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hold_release_ready", EW'(in_ready), EW'(1));
    chk("hold_release_busy", EW'(busy), '0);
    drain();

    // reset during the second RUN cycle abandons the operation
    send(rand_w(), rand_w(), 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", EW'(in_ready), EW'(1));
    chk("abort_out_valid", EW'(out_valid), '0);
    chk("abort_sum", EW'(out_sum), '0);
    chk("abort_busy", EW'(busy), '0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) n++;
    end
    chk("abort_no_result", EW'(n), '0);

    // random traffic with random output stalls
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) send(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'b1);
    drain();
    ready_mode = 0;

`ifdef MWADD_OVF_EN
    send({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b1);
    send({1'b1, {(W-1){1'b0}}}, '1, 1'b0, 1'b1);
    send(W'(5), W'(3), 1'b0, 1'b1);
    drain();
`endif

    chk("final_queue_empty", EW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
Sequential wide adder that computes A + B + cin on NUM_WORDS×32-bit operands by iterating the existing 32-bit prefix adder once per word.
- Feeds the adder the word-aligned slices of A and B plus the registered carry.
- Consumes the adder's sum/cout, assembling the wide result LSW-first.
- Valid/ready handshake on both input and output.
- Sits in the datapath as the wide-operand front/back end of prefix_adder_32bit.

Parameters:
- NUM_WORDS, 4, number of 32-bit words per operand (>= 1); total width W = 32*NUM_WORDS.
- WORD_W, 32, local constant fixed by the adder; not overridable.

Ports:
- clk  input  1  single clock, all state rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry into word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  A + B + cin, low W bits.
- out_cout  output  1  carry out of the top word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: state=IDLE, idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0, busy=0, so in_ready=1 on the first post-reset cycle.
- FSM states are IDLE, RUN and DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register in_a, in_b, carry<=in_cin and idx<=0, then go to RUN.
  - RUN: the adder sees a=A[idx], b=B[idx], cin=carry.
    - Each cycle: out_sum word idx <= sum; carry<=cout; idx<=idx+1.
    - When idx==NUM_WORDS-1, out_cout<=cout and go to DONE.
  - DONE: out_valid=1. out_sum and out_cout are held stable until out_valid&&out_ready, then go to IDLE.
- Latency: accept at cycle T gives out_valid in cycle T+NUM_WORDS+1.
- Throughput: one operation per NUM_WORDS+2 cycles. There is no same-cycle turnaround from DONE to IDLE-accept; in_ready=0 in DONE.
- in_valid while not in IDLE is ignored; operands are not sampled.
- Input operands are captured once. Changes on in_a/in_b after accept have no effect.
- NUM_WORDS=1: exactly one RUN cycle; idx register width is max(1, clog2(NUM_WORDS)).
- Carry chain wraps only within the operation. The final carry goes to out_cout; the carry register is not reused across operations.
- Reset in RUN or DONE: the operation is abandoned, no out_valid pulse is produced, and the block returns to IDLE next cycle.
- out_ready held high: DONE lasts exactly one cycle.
- rst has priority over all handshakes.

Optional Feature:
MWADD_OVF_EN
- Defined: adds output port out_ovf (1 bit).
  - Signed two's-complement overflow of the W-bit add: carry into the MSB XOR out_cout.
  - Registered together with out_cout; reset 0; held in DONE.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mwadd_pkg holds:
  - typedef enum state_t {IDLE, RUN, DONE};
  - localparam WORD_W=32.
  - A function for idx width.
- Sub-module: instantiate the existing prefix_adder_32bit once as the per-word adder. There is no other sub-module; the FSM, registers and word mux are in multiword_add_seq.

Test Plan:
1. NUM_WORDS=4, A=all-ones (128 bits), B=0, cin=1 -> out_sum=0, out_cout=1; out_valid rises exactly 5 cycles after accept.
2. A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, cin=0 -> out_sum=0x...0001_0000_0000, out_cout=0; checks the inter-word carry.
3. Result ready, out_ready=0 for 10 cycles with in_valid=1 and changing in_a -> out_valid stays 1, out_sum stable, in_ready=0, nothing accepted; out_ready=1 -> IDLE next cycle.
4. rst asserted in the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, out_sum=0; no result is ever emitted for that operation.
5. 1000 random A, B, cin with random out_ready stalls -> {out_cout,out_sum} == A+B+cin (129-bit model) for every handshake.
6. MWADD_OVF_EN defined:
   - A=0x7FFF...F, B=1 -> out_ovf=1.
   - A=0x8000...0, B=all-ones -> out_ovf=1, out_cout=1.
   - A=5, B=3 -> out_ovf=0.
